// File: rtl/chip_tester_pkg.sv
// Shared types and helpers for the 2-input gate-array tester: gate operation
// codes, controller states and the expected-output function.
package chip_tester_pkg;

    localparam int NUM_VECTORS = 4;

    typedef enum logic [2:0] {
        OP_NAND  = 3'd0,
        OP_NOR   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_RSVD6 = 3'd6,
        OP_RSVD7 = 3'd7
    } gate_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } tester_state_t;

    // Expected Y of one gate for inputs a/b; reserved codes yield 0.
    function automatic logic gate_expected(gate_op_t op, logic a, logic b);
        logic y;
        case (op)
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    function automatic logic op_is_reserved(gate_op_t op);
        return (op == OP_RSVD6) || (op == OP_RSVD7);
    endfunction

endpackage

// File: rtl/chip_tester_settle_timer.sv
// Load/count-down timer; done is high on the last counted cycle while enabled.
module chip_tester_settle_timer #(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != {WIDTH{1'b0}})) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = en && (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/chip_gate_array_tester.sv
// Exhaustive tester for NUM_GATES identical 2-input gates with run-time op select.
// Define CHIP_TESTER_SYNC_EN to pass Pin_Y through a 2-flop synchroniser.
module chip_gate_array_tester
    import chip_tester_pkg::*;
#(
    parameter int NUM_GATES     = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic [2:0]           Gate_op,
    input  logic                 DISP_RSLT,
    output logic [NUM_GATES-1:0] Pin_A,
    output logic [NUM_GATES-1:0] Pin_B,
    input  logic [NUM_GATES-1:0] Pin_Y,
    output logic                 Done,
    output logic                 RSLT,
    output logic [NUM_GATES-1:0] Fail_mask
);

    localparam int TIMER_W = $clog2(SETTLE_CYCLES + 3);

    logic [NUM_GATES-1:0] y_cmp_s;

`ifdef CHIP_TESTER_SYNC_EN
    // Two extra drive cycles cover the synchroniser delay.
    localparam int DRIVE_CYCLES = SETTLE_CYCLES + 2;

    logic [NUM_GATES-1:0] y_meta_q, y_meta_d;
    logic [NUM_GATES-1:0] y_sync_q, y_sync_d;

    assign y_meta_d = Pin_Y;
    assign y_sync_d = y_meta_q;

    // Synchroniser flops for the returning gate outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            y_meta_q <= {NUM_GATES{1'b0}};
            y_sync_q <= {NUM_GATES{1'b0}};
        end else begin
            y_meta_q <= y_meta_d;
            y_sync_q <= y_sync_d;
        end
    end

    assign y_cmp_s = y_sync_q;
`else
    localparam int DRIVE_CYCLES = SETTLE_CYCLES;

    assign y_cmp_s = Pin_Y;
`endif

    tester_state_t        state_q, state_d;
    gate_op_t             op_q, op_d;
    logic [1:0]           vec_q, vec_d;
    logic [NUM_GATES-1:0] fail_mask_q, fail_mask_d;
    logic                 rslt_q, rslt_d;
    logic                 done_q, done_d;
    logic [NUM_GATES-1:0] pin_a_q, pin_a_d;
    logic [NUM_GATES-1:0] pin_b_q, pin_b_d;
    logic                 timer_load_s;
    logic                 timer_done_s;
    logic                 timer_en_s;
    logic                 exp_s;
    logic [NUM_GATES-1:0] sample_mask_s;
    logic                 drive_s;

    assign timer_en_s    = (state_q == ST_DRIVE);
    assign exp_s         = gate_expected(op_q, vec_q[1], vec_q[0]);
    assign sample_mask_s = fail_mask_q | (y_cmp_s ^ {NUM_GATES{exp_s}});

    chip_tester_settle_timer #(
        .WIDTH (TIMER_W)
    ) u_settle_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (timer_load_s),
        .load_val (TIMER_W'(DRIVE_CYCLES - 1)),
        .en       (timer_en_s),
        .done     (timer_done_s)
    );

    // Next-state logic; outputs are registered from the next state so they
    // line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        vec_d        = vec_q;
        fail_mask_d  = fail_mask_q;
        rslt_d       = rslt_q;
        timer_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Run) begin
                    state_d     = ST_INIT;
                    op_d        = gate_op_t'(Gate_op);
                    vec_d       = 2'd0;
                    fail_mask_d = {NUM_GATES{1'b0}};
                    rslt_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (op_is_reserved(op_q)) begin
                    fail_mask_d = {NUM_GATES{1'b1}};
                    rslt_d      = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    timer_load_s = 1'b1;
                    state_d      = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (timer_done_s) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_SAMPLE: begin
                fail_mask_d = sample_mask_s;
                if (vec_q == 2'(NUM_VECTORS - 1)) begin
                    rslt_d  = ~|sample_mask_s;
                    state_d = ST_DONE;
                end else begin
                    vec_d        = vec_q + 2'd1;
                    timer_load_s = 1'b1;
                    state_d      = ST_DRIVE;
                end
            end
            ST_DONE: begin
                if (DISP_RSLT) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle.
    always_comb begin
        drive_s = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
        done_d  = (state_d == ST_DONE);
        pin_a_d = drive_s ? {NUM_GATES{vec_d[1]}} : {NUM_GATES{1'b0}};
        pin_b_d = drive_s ? {NUM_GATES{vec_d[0]}} : {NUM_GATES{1'b0}};
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NAND;
            vec_q       <= 2'd0;
            fail_mask_q <= {NUM_GATES{1'b0}};
            rslt_q      <= 1'b0;
            done_q      <= 1'b0;
            pin_a_q     <= {NUM_GATES{1'b0}};
            pin_b_q     <= {NUM_GATES{1'b0}};
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            vec_q       <= vec_d;
            fail_mask_q <= fail_mask_d;
            rslt_q      <= rslt_d;
            done_q      <= done_d;
            pin_a_q     <= pin_a_d;
            pin_b_q     <= pin_b_d;
        end
    end

    assign Pin_A     = pin_a_q;
    assign Pin_B     = pin_b_q;
    assign Done      = done_q;
    assign RSLT      = rslt_q;
    assign Fail_mask = fail_mask_q;

endmodule
